// File: rtl/biquad_scheduler_if.sv
// Sample and coefficient bus for the biquad scheduler: sample handshake,
// filtered output, shadow-bank coefficient writes, bank commit and overrun flag.
interface biquad_scheduler_if #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int COEF_WIDTH   = 24
);
    logic                           in_valid;
    logic                           in_ready;
    logic signed [SAMPLE_WIDTH-1:0] sample_in;
    logic                           out_valid;
    logic signed [SAMPLE_WIDTH-1:0] sample_out;
    logic                           coef_wr_en;
    logic [7:0]                     coef_wr_addr;
    logic signed [COEF_WIDTH-1:0]   coef_wr_data;
    logic                           coef_swap;
    logic                           coef_swap_done;
    logic                           overrun;

    modport master (
        output in_valid, sample_in, coef_wr_en, coef_wr_addr, coef_wr_data, coef_swap,
        input  in_ready, out_valid, sample_out, coef_swap_done, overrun
    );

    modport slave (
        input  in_valid, sample_in, coef_wr_en, coef_wr_addr, coef_wr_data, coef_swap,
        output in_ready, out_valid, sample_out, coef_swap_done, overrun
    );
endinterface

// File: rtl/biquad_scheduler.sv
// Cascaded biquad filter sharing one signed multiply-accumulate across all
// sections. Each section takes five MAC cycles plus one write-back cycle.
// Coefficients live in two banks; software fills the inactive bank and then
// requests a commit, which is applied only while idle between samples.
// The accumulator width assumes COEF_WIDTH <= SAMPLE_WIDTH + 3.
module biquad_scheduler #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int COEF_WIDTH   = 24,
    parameter int COEF_FRAC    = 22,
    parameter int NUM_STAGES   = 4
) (
    input logic               sample_clock,
    input logic               reset,
    biquad_scheduler_if.slave bus
);
    localparam int ACC_WIDTH  = 2 * SAMPLE_WIDTH + 3;
    localparam int PROD_WIDTH = SAMPLE_WIDTH + COEF_WIDTH;
    localparam int NUM_COEFS  = 5 * NUM_STAGES;
    localparam int IDX_BITS   = $clog2(NUM_COEFS);
    localparam int STAGE_BITS = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [STAGE_BITS-1:0]       LAST_STAGE = STAGE_BITS'(NUM_STAGES - 1);
    localparam logic signed [COEF_WIDTH-1:0] COEF_ONE  = COEF_WIDTH'(1) << COEF_FRAC;
    localparam logic signed [ACC_WIDTH-1:0] ROUND_HALF = ACC_WIDTH'(1) << (COEF_FRAC - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX    = (ACC_WIDTH'(1) << (SAMPLE_WIDTH - 1)) - ACC_WIDTH'(1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN    = -(ACC_WIDTH'(1) << (SAMPLE_WIDTH - 1));

    typedef enum logic [1:0] {IDLE, MAC, WB, DONE} state_t;

    state_t                         state;
    logic [STAGE_BITS-1:0]          stage;
    logic [2:0]                     tap;
    logic signed [ACC_WIDTH-1:0]    acc;
    logic signed [SAMPLE_WIDTH-1:0] x_cur;
    logic                           active_bank;
    logic                           swap_pending;

    logic signed [SAMPLE_WIDTH-1:0] x1 [NUM_STAGES];
    logic signed [SAMPLE_WIDTH-1:0] x2 [NUM_STAGES];
    logic signed [SAMPLE_WIDTH-1:0] y1 [NUM_STAGES];
    logic signed [SAMPLE_WIDTH-1:0] y2 [NUM_STAGES];

    logic signed [COEF_WIDTH-1:0]   bank0 [NUM_COEFS];
    logic signed [COEF_WIDTH-1:0]   bank1 [NUM_COEFS];

    logic [IDX_BITS-1:0]            coef_idx;
    logic [IDX_BITS-1:0]            wr_idx;
    logic                           wr_in_range;
    logic signed [COEF_WIDTH-1:0]   coef_sel;
    logic signed [SAMPLE_WIDTH-1:0] data_sel;
    logic signed [PROD_WIDTH-1:0]   product;
    logic signed [ACC_WIDTH-1:0]    prod_ext;
    logic signed [ACC_WIDTH-1:0]    acc_next;
    logic signed [ACC_WIDTH-1:0]    shifted;
    logic signed [SAMPLE_WIDTH-1:0] y_sat;

    assign bus.in_ready = (state == IDLE);
    assign wr_in_range  = (int'(bus.coef_wr_addr) < NUM_COEFS);
    assign wr_idx       = IDX_BITS'(bus.coef_wr_addr);

    // Pick the current tap's coefficient and operand, form the product, and
    // add it (b taps) or subtract it (a taps) from the running accumulator.
    always_comb begin
        coef_idx = IDX_BITS'(5 * int'(stage) + int'(tap));
        coef_sel = active_bank ? bank1[coef_idx] : bank0[coef_idx];
        case (tap)
            3'd1:    data_sel = x1[stage];
            3'd2:    data_sel = x2[stage];
            3'd3:    data_sel = y1[stage];
            3'd4:    data_sel = y2[stage];
            default: data_sel = x_cur;
        endcase
        product  = $signed({{COEF_WIDTH{data_sel[SAMPLE_WIDTH-1]}}, data_sel})
                 * $signed({{SAMPLE_WIDTH{coef_sel[COEF_WIDTH-1]}}, coef_sel});
        prod_ext = $signed({{(ACC_WIDTH - PROD_WIDTH){product[PROD_WIDTH-1]}}, product});
        acc_next = (tap >= 3'd3) ? (acc - prod_ext) : (acc + prod_ext);
    end

    // Round half up back to sample scale, then clamp to the sample range.
    always_comb begin
        shifted = (acc + ROUND_HALF) >>> COEF_FRAC;
        if (shifted > SAT_MAX) begin
            y_sat = {1'b0, {(SAMPLE_WIDTH - 1){1'b1}}};
        end else if (shifted < SAT_MIN) begin
            y_sat = {1'b1, {(SAMPLE_WIDTH - 1){1'b0}}};
        end else begin
            y_sat = shifted[SAMPLE_WIDTH-1:0];
        end
    end

    // Shadow-bank writes always land in the bank not currently in use.
    always_ff @(posedge sample_clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_COEFS; i++) begin
                bank0[i] <= (i % 5 == 0) ? COEF_ONE : '0;
                bank1[i] <= (i % 5 == 0) ? COEF_ONE : '0;
            end
        end else if (bus.coef_wr_en && wr_in_range) begin
            if (active_bank) begin
                bank0[wr_idx] <= bus.coef_wr_data;
            end else begin
                bank1[wr_idx] <= bus.coef_wr_data;
            end
        end
    end

    // Sample scheduler: accept, MAC through each section, write back, emit.
    always_ff @(posedge sample_clock or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            stage              <= '0;
            tap                <= '0;
            acc                <= '0;
            x_cur              <= '0;
            active_bank        <= 1'b0;
            swap_pending       <= 1'b0;
            bus.out_valid      <= 1'b0;
            bus.sample_out     <= '0;
            bus.coef_swap_done <= 1'b0;
            bus.overrun        <= 1'b0;
            for (int i = 0; i < NUM_STAGES; i++) begin
                x1[i] <= '0;
                x2[i] <= '0;
                y1[i] <= '0;
                y2[i] <= '0;
            end
        end else begin
            bus.out_valid      <= 1'b0;
            bus.coef_swap_done <= 1'b0;
            if (bus.in_valid && (state != IDLE)) begin
                bus.overrun <= 1'b1;
            end
            if (bus.coef_swap) begin
                swap_pending <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (swap_pending) begin
                        active_bank        <= ~active_bank;
                        swap_pending       <= 1'b0;
                        bus.coef_swap_done <= 1'b1;
                    end
                    if (bus.in_valid) begin
                        x_cur <= bus.sample_in;
                        stage <= '0;
                        tap   <= '0;
                        acc   <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc_next;
                    if (tap == 3'd4) begin
                        state <= WB;
                    end else begin
                        tap <= tap + 3'd1;
                    end
                end
                WB: begin
                    x2[stage] <= x1[stage];
                    x1[stage] <= x_cur;
                    y2[stage] <= y1[stage];
                    y1[stage] <= y_sat;
                    x_cur     <= y_sat;
                    if (stage == LAST_STAGE) begin
                        state <= DONE;
                    end else begin
                        stage <= stage + 1'b1;
                        tap   <= '0;
                        acc   <= '0;
                        state <= MAC;
                    end
                end
                DONE: begin
                    bus.sample_out <= x_cur;
                    bus.out_valid  <= 1'b1;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_biquad_scheduler.sv
// Directed bench for biquad_scheduler: pass-through, gain swaps, saturation,
// recursion, overrun and reset mid-sample, with a queue of expected outputs.
module tb_biquad_scheduler;
    localparam int SW = 24;
    localparam int CW = 24;

    logic sample_clock = 1'b0;
    logic reset;

    logic signed [SW-1:0] expect_q [$];
    int vectors     = 0;
    int miscompares = 0;
    int out_pulses  = 0;
    int done_pulses = 0;

    biquad_scheduler_if #(.SAMPLE_WIDTH(SW), .COEF_WIDTH(CW)) bus ();

    biquad_scheduler #(
        .SAMPLE_WIDTH(SW),
        .COEF_WIDTH  (CW),
        .COEF_FRAC   (22),
        .NUM_STAGES  (4)
    ) dut (
        .sample_clock(sample_clock),
        .reset       (reset),
        .bus         (bus.slave)
    );

    // Free-running sample clock.
    always #5 sample_clock = ~sample_clock;

    // Count output and commit pulses just after each rising edge.
    always @(posedge sample_clock) begin
        #1;
        if (bus.out_valid === 1'b1) out_pulses++;
        if (bus.coef_swap_done === 1'b1) done_pulses++;
    end

    // Hard stop in case the sequence stalls.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: observed timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic signed [SW-1:0] s);
        checkOutput("ready_before_accept", 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b1;
        bus.sample_in = s;
        @(negedge sample_clock);
        bus.in_valid  = 1'b0;
    endtask

    task automatic waitResult(input string tag, input int already);
        int lat = already;
        logic ready_ok = 1'b1;
        logic signed [SW-1:0] exp_v;
        while (bus.out_valid !== 1'b1 && lat < 200) begin
            if (bus.in_ready !== 1'b0) ready_ok = 1'b0;
            @(negedge sample_clock);
            lat++;
        end
        checkOutput({tag, "_latency"}, 32'(lat), 32'd25);
        checkOutput({tag, "_ready_low"}, 32'(ready_ok), 32'd1);
        checkOutput({tag, "_ready_at_out"}, 32'(bus.in_ready), 32'd1);
        exp_v = 'x;
        if (expect_q.size() > 0) exp_v = expect_q.pop_front();
        checkOutput(tag, 32'(bus.sample_out), 32'(exp_v));
    endtask

    task automatic runSample(input string tag, input logic signed [SW-1:0] s, input logic signed [SW-1:0] e);
        expect_q.push_back(e);
        applyStimulus(s);
        waitResult(tag, 0);
    endtask

    task automatic writeCoef(input logic [7:0] addr, input logic signed [CW-1:0] data);
        bus.coef_wr_en   = 1'b1;
        bus.coef_wr_addr = addr;
        bus.coef_wr_data = data;
        @(negedge sample_clock);
        bus.coef_wr_en   = 1'b0;
    endtask

    task automatic doSwap(input string tag);
        int base = done_pulses;
        bus.coef_swap = 1'b1;
        @(negedge sample_clock);
        bus.coef_swap = 1'b0;
        repeat (4) @(negedge sample_clock);
        checkOutput(tag, 32'(done_pulses - base), 32'd1);
    endtask

    task automatic resetDut();
        reset = 1'b1;
        repeat (2) @(negedge sample_clock);
        reset = 1'b0;
        @(negedge sample_clock);
    endtask

    initial begin
        int base;
        bus.in_valid     = 1'b0;
        bus.sample_in    = '0;
        bus.coef_wr_en   = 1'b0;
        bus.coef_wr_addr = '0;
        bus.coef_wr_data = '0;
        bus.coef_swap    = 1'b0;
        @(negedge sample_clock);
        resetDut();

        // reset state
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_swap_done", 32'(bus.coef_swap_done), 32'd0);
        checkOutput("rst_overrun", 32'(bus.overrun), 32'd0);
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("rst_sample_out", 32'(bus.sample_out), 32'd0);

        // pass-through with reset coefficients
        runSample("passthru", 24'sh100000, 24'sh100000);

        // immediate gain swap: stage0 b0 = 0.5
        writeCoef(8'd0, 24'sh200000);
        doSwap("swap_idle_done");
        runSample("gain_half", 24'sh400000, 24'sh200000);

        // swap requested mid-sample is deferred to idle
        writeCoef(8'd0, 24'sh100000);
        base = done_pulses;
        expect_q.push_back(24'sh200000);
        applyStimulus(24'sh400000);
        repeat (4) @(negedge sample_clock);
        bus.coef_swap = 1'b1;
        @(negedge sample_clock);
        bus.coef_swap = 1'b0;
        waitResult("swap_old_bank", 5);
        checkOutput("swap_deferred", 32'(done_pulses - base), 32'd0);
        repeat (3) @(negedge sample_clock);
        checkOutput("swap_after_idle", 32'(done_pulses - base), 32'd1);
        runSample("gain_quarter", 24'sh400000, 24'sh100000);

        // saturation: stage0 b0 = 1.5
        writeCoef(8'd0, 24'sh600000);
        doSwap("swap_sat_done");
        runSample("sat_pos", 24'sh7FFFFF, 24'sh7FFFFF);
        runSample("sat_neg", 24'sh800000, 24'sh800000);
        runSample("sat_mid", 24'sh100000, 24'sh180000);

        // overrun: extra valids while busy, then back-to-back accept
        @(negedge sample_clock);
        checkOutput("ovr_clear_before", 32'(bus.overrun), 32'd0);
        base = out_pulses;
        expect_q.push_back(24'sh180000);
        expect_q.push_back(24'sh180000);
        checkOutput("ovr_ready_before", 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b1;
        bus.sample_in = 24'sh100000;
        @(negedge sample_clock);
        repeat (3) @(negedge sample_clock);
        checkOutput("ovr_set", 32'(bus.overrun), 32'd1);
        waitResult("ovr_first", 3);
        @(negedge sample_clock);
        bus.in_valid = 1'b0;
        checkOutput("b2b_accepted", 32'(bus.in_ready), 32'd0);
        waitResult("ovr_second", 0);
        repeat (30) @(negedge sample_clock);
        checkOutput("ovr_out_count", 32'(out_pulses - base), 32'd2);
        checkOutput("ovr_sticky", 32'(bus.overrun), 32'd1);

        // recursion from clean histories: stage0 a1 = -0.5
        resetDut();
        writeCoef(8'd0, 24'sh400000);
        writeCoef(8'd3, 24'shE00000);
        doSwap("swap_rec_done");
        runSample("rec0", 24'sh100000, 24'sh100000);
        runSample("rec1", 24'sh000000, 24'sh080000);
        runSample("rec2", 24'sh000000, 24'sh040000);
        runSample("rec3", 24'sh000000, 24'sh020000);

        // reset during the second sample of the recursion
        resetDut();
        writeCoef(8'd0, 24'sh400000);
        writeCoef(8'd3, 24'shE00000);
        doSwap("swap_rec2_done");
        runSample("rst_rec0", 24'sh100000, 24'sh100000);
        base = out_pulses;
        applyStimulus(24'sh000000);
        repeat (9) @(negedge sample_clock);
        reset = 1'b1;
        @(negedge sample_clock);
        reset = 1'b0;
        repeat (40) @(negedge sample_clock);
        checkOutput("rst_no_out", 32'(out_pulses - base), 32'd0);
        checkOutput("rst_mid_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("rst_mid_sample_out", 32'(bus.sample_out), 32'd0);
        runSample("rst_coef_pass", 24'sh100000, 24'sh100000);
        runSample("rst_coef_zero", 24'sh000000, 24'sh000000);

        // reload and replay the impulse
        writeCoef(8'd0, 24'sh400000);
        writeCoef(8'd3, 24'shE00000);
        doSwap("swap_replay_done");
        runSample("replay0", 24'sh100000, 24'sh100000);
        runSample("replay1", 24'sh000000, 24'sh080000);
        runSample("replay2", 24'sh000000, 24'sh040000);
        runSample("replay3", 24'sh000000, 24'sh020000);

        repeat (3) @(negedge sample_clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
